// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size code 3 behaves as a word access.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: 64-bit store lane mask/data and load extract with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  lane_mask,
  output logic [63:0] lane_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    lane_mask = ((8'd1 << nbytes(size)) - 8'd1) << off;
    lane_data = {32'd0, wdata} << {off, 3'b000};
    shifted   = 32'(rword >> {off, 3'b000});
    case (size)
      SZ_B:    load_data = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the data-RAM bus for loads/stores, splitting
// misaligned accesses into two word beats and stalling the pipeline meanwhile.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("mem_stage_lsu: DATA_W must be 32");
  end

  lsu_state_t        state;
  logic              mem_op;
  logic [ADDR_W-1:0] beat0_addr;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              split_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [3:0]        be1_q;
  logic [31:0]       wdata1_q;
  logic [31:0]       lo_q;

  logic [1:0]        a_off;
  logic [1:0]        a_size;
  logic              a_uns;
  logic [63:0]       a_rword;
  logic [7:0]        lane_mask;
  logic [63:0]       lane_data;
  logic [31:0]       load_data;

  // One aligner serves both directions: request fields in IDLE, latched fields during beats.
  always_comb begin
    mem_op     = req_valid & (req_load | req_store);
    stall_o    = (state == IDLE && mem_op) || state == BEAT0 || state == BEAT1;
    beat0_addr = {req_addr[ADDR_W-1:2], 2'b00};
    if (state == IDLE) begin
      a_off  = req_addr[1:0];
      a_size = req_size;
      a_uns  = req_unsigned;
    end else begin
      a_off  = off_q;
      a_size = size_q;
      a_uns  = uns_q;
    end
    a_rword = (state == BEAT1) ? {bus_rdata, lo_q} : {32'd0, bus_rdata};
  end

  lsu_align u_align (
    .off       (a_off),
    .size      (a_size),
    .uns       (a_uns),
    .wdata     (req_wdata),
    .rword     (a_rword),
    .lane_mask (lane_mask),
    .lane_data (lane_data),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_o    <= 1'b0;
      rdata_o   <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      split_q   <= 1'b0;
      addr1_q   <= '0;
      be1_q     <= '0;
      wdata1_q  <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state     <= BEAT0;
            bus_valid <= 1'b1;
            bus_we    <= req_store;
            bus_addr  <= beat0_addr;
            bus_be    <= lane_mask[3:0];
            bus_wdata <= req_store ? lane_data[31:0] : '0;
            addr1_q   <= beat0_addr + ADDR_W'(4);
            be1_q     <= lane_mask[7:4];
            wdata1_q  <= req_store ? lane_data[63:32] : '0;
            split_q   <= |lane_mask[7:4];
            off_q     <= req_addr[1:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
          end
        end
        BEAT0, BEAT1: begin
          if (bus_ready) begin
            if (state == BEAT0 && split_q) begin
              state     <= BEAT1;
              bus_addr  <= addr1_q;
              bus_be    <= be1_q;
              bus_wdata <= wdata1_q;
              lo_q      <= bus_rdata;
            end else begin
              state     <= DONE;
              done_o    <= 1'b1;
              bus_valid <= 1'b0;
              bus_we    <= 1'b0;
              bus_addr  <= '0;
              bus_be    <= '0;
              bus_wdata <= '0;
              if (!bus_we) rdata_o <= load_data;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, corner sequences,
// and randomized traffic checked against a byte-addressed memory model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, done_o;
  logic [31:0] rdata_o;
  logic        bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit        ld, st;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] addr, wd, r0, r1;
    int        nbeats;
    bit [31:0] a0; bit [3:0] be0; bit [31:0] w0;
    bit [31:0] a1; bit [3:0] be1; bit [31:0] w1;
    bit [31:0] rd;
    int        stalls;
  } vec_t;

  vec_t vecs[12];

  // Byte-level memory models: one seen through the bus, one updated from op semantics.
  bit [7:0] busmem[bit [31:0]];
  bit [7:0] refmem[bit [31:0]];

  function automatic bit [7:0] dflt(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic bit [7:0] bus_rd(input bit [31:0] a);
    if (busmem.exists(a)) return busmem[a];
    return dflt(a);
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    if (refmem.exists(a)) return refmem[a];
    return dflt(a);
  endfunction

  task automatic set_req(input bit v, input bit ld, input bit st, input bit [1:0] sz,
                         input bit uns, input bit [31:0] a, input bit [31:0] wd);
    req_valid = v; req_load = ld; req_store = st; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  beat = 0;
    int  stalls = 0;
    int  cyc = 0;
    bit  done = 0;
    @(negedge clk);
    set_req(1, v.ld, v.st, v.sz, v.uns, v.addr, v.wd);
    bus_ready = 0;
    #1;
    if (stall_o) stalls++;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done_o) begin
        done = 1;
        chk($sformatf("vec%0d_beats", idx), beat, v.nbeats);
        chk($sformatf("vec%0d_done_stall", idx), stall_o, 0);
        if (v.ld && !v.st) chk($sformatf("vec%0d_rdata", idx), rdata_o, v.rd);
        req_valid = 0;
        bus_ready = 0;
      end else begin
        if (stall_o) stalls++;
        if (bus_valid) begin
          if (beat == 0) begin
            chk($sformatf("vec%0d_addr0", idx), bus_addr, v.a0);
            chk($sformatf("vec%0d_be0", idx), bus_be, v.be0);
            chk($sformatf("vec%0d_wdata0", idx), bus_wdata, v.w0);
            chk($sformatf("vec%0d_we0", idx), bus_we, v.st);
          end else if (beat == 1) begin
            chk($sformatf("vec%0d_addr1", idx), bus_addr, v.a1);
            chk($sformatf("vec%0d_be1", idx), bus_be, v.be1);
            chk($sformatf("vec%0d_wdata1", idx), bus_wdata, v.w1);
            chk($sformatf("vec%0d_we1", idx), bus_we, v.st);
          end
          bus_ready = 1;
          bus_rdata = (beat == 0) ? v.r0 : v.r1;
          beat++;
        end else begin
          bus_ready = 0;
        end
      end
    end
    if (!done) chk($sformatf("vec%0d_timeout", idx), 0, 1);
    chk($sformatf("vec%0d_stalls", idx), stalls, v.stalls);
    @(negedge clk);
    chk($sformatf("vec%0d_done_single", idx), done_o, 0);
    chk($sformatf("vec%0d_bus_idle", idx), bus_valid, 0);
  endtask

  task automatic run_random(input int nops);
    int        ops = 0, cyc = 0, beats = 0, exp_beats = 0, nb, r, k;
    bit        inflight = 0, exp_load = 0, prev_wait = 0, st;
    bit [31:0] exp_rd = 0, a, wd, word;
    bit [31:0] pa = 0, pw = 0;
    bit [3:0]  pbe = 0;
    bit        pwe = 0;
    while (ops < nops && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_wait) begin
        chk("rnd_hold_valid", bus_valid, 1);
        chk("rnd_hold_addr", bus_addr, pa);
        chk("rnd_hold_be", bus_be, pbe);
        chk("rnd_hold_wdata", bus_wdata, pw);
        chk("rnd_hold_we", bus_we, pwe);
      end
      prev_wait = 0;
      if (done_o) begin
        chk("rnd_done_expected", inflight, 1);
        chk("rnd_beats", beats, exp_beats);
        if (exp_load) chk("rnd_rdata", rdata_o, exp_rd);
        inflight = 0;
        ops++;
      end
      if (bus_valid) begin
        chk("rnd_beat_stall", stall_o, 1);
        chk("rnd_beat_align", bus_addr[1:0], 0);
        chk("rnd_beat_we", bus_we, !exp_load);
        if (exp_load) chk("rnd_load_wdata", bus_wdata, 0);
        if ($urandom_range(0, 2) != 0) begin
          bus_ready = 1;
          beats++;
          if (bus_we) begin
            for (int j = 0; j < 4; j++)
              if (bus_be[j]) busmem[bus_addr + 32'(j)] = 8'(bus_wdata >> (8 * j));
          end else begin
            word = 0;
            for (int j = 0; j < 4; j++) word |= 32'(bus_rd(bus_addr + 32'(j))) << (8 * j);
            bus_rdata = word;
          end
        end else begin
          bus_ready = 0;
          bus_rdata = $urandom;
          prev_wait = 1;
          pa = bus_addr; pbe = bus_be; pw = bus_wdata; pwe = bus_we;
        end
      end else begin
        bus_ready = 0;
      end
      if (!inflight) begin
        r = $urandom_range(0, 9);
        a = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 23));
        wd = $urandom;
        if (r == 0) begin
          set_req(0, 1, 0, 2'($urandom_range(0, 3)), 0, a, wd);
        end else if (r == 1) begin
          set_req(1, 0, 0, 2'($urandom_range(0, 3)), 0, a, wd);
        end else begin
          k  = $urandom_range(0, 2);
          st = (k != 0);
          set_req(1, k != 1, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, wd);
          nb = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
          exp_beats = (int'(a[1:0]) + nb > 4) ? 2 : 1;
          exp_load  = !st;
          if (st) begin
            for (int i = 0; i < nb; i++) refmem[a + 32'(i)] = 8'(wd >> (8 * i));
          end else begin
            exp_rd = 0;
            for (int i = 0; i < nb; i++) exp_rd |= 32'(ref_rd(a + 32'(i))) << (8 * i);
            if (!req_unsigned && nb < 4 && exp_rd[8 * nb - 1]) exp_rd |= 32'hFFFF_FFFF << (8 * nb);
          end
          beats    = 0;
          inflight = 1;
        end
        if (!done_o) begin
          #1;
          chk("rnd_idle_stall", stall_o, inflight);
        end
      end
    end
    if (ops < nops) chk("rnd_timeout", ops, nops);
    req_valid = 0;
    bus_ready = 0;
  endtask

  initial begin
    bit [31:0] sa, sb, sw;
    int        stalls;
    bit        got_done;

    vecs[0]  = '{0,1,2'd2,0, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 2};
    vecs[1]  = '{1,0,2'd0,0, 32'h203, 0, 32'h80123456, 0, 1, 32'h200, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 2};
    vecs[2]  = '{1,0,2'd0,1, 32'h203, 0, 32'h80123456, 0, 1, 32'h200, 4'h8, 0, 0, 0, 0, 32'h00000080, 2};
    vecs[3]  = '{1,0,2'd2,0, 32'h102, 0, 32'h11223344, 32'h55667788, 2, 32'h100, 4'hC, 0,
                 32'h104, 4'h3, 0, 32'h77881122, 3};
    vecs[4]  = '{0,1,2'd1,0, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0, 2, 32'hFFFFFFFC, 4'h8, 32'hCD000000,
                 32'h0, 4'h1, 32'h000000AB, 0, 3};
    vecs[5]  = '{1,0,2'd1,0, 32'h102, 0, 32'h80011234, 0, 1, 32'h100, 4'hC, 0, 0, 0, 0, 32'hFFFF8001, 2};
    vecs[6]  = '{1,0,2'd1,1, 32'h002, 0, 32'h80011234, 0, 1, 32'h000, 4'hC, 0, 0, 0, 0, 32'h00008001, 2};
    vecs[7]  = '{0,1,2'd0,0, 32'h001, 32'h12345678, 0, 0, 1, 32'h000, 4'h2, 32'h34567800, 0, 0, 0, 0, 2};
    vecs[8]  = '{1,1,2'd3,0, 32'h008, 32'h01020304, 32'hFFFFFFFF, 0, 1, 32'h008, 4'hF, 32'h01020304,
                 0, 0, 0, 0, 2};
    vecs[9]  = '{1,0,2'd2,0, 32'h400, 0, 32'hCAFEF00D, 0, 1, 32'h400, 4'hF, 0, 0, 0, 0, 32'hCAFEF00D, 2};
    vecs[10] = '{1,0,2'd1,1, 32'h003, 0, 32'hAA000000, 32'h000000BB, 2, 32'h000, 4'h8, 0,
                 32'h004, 4'h1, 0, 32'h0000BBAA, 3};
    vecs[11] = '{0,1,2'd2,0, 32'h007, 32'h11223344, 0, 0, 2, 32'h004, 4'h8, 32'h44000000,
                 32'h008, 4'h7, 32'h00112233, 0, 3};

    reset = 1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    bus_ready = 0;
    bus_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    reset = 0;

    // Non-memory instructions pass straight through.
    set_req(1, 0, 0, 2'd2, 0, 32'h40, 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("nonmem_stall", stall_o, 0);
      chk("nonmem_bus_valid", bus_valid, 0);
      chk("nonmem_done", done_o, 0);
    end
    req_valid = 0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // bus_ready held low for three cycles in BEAT0.
    @(negedge clk);
    set_req(1, 0, 1, 2'd2, 0, 32'h10, 32'h55AA55AA);
    bus_ready = 0;
    #1;
    stalls = stall_o ? 1 : 0;
    @(negedge clk);
    chk("wait_valid", bus_valid, 1);
    sa = bus_addr; sb = 32'(bus_be); sw = bus_wdata;
    chk("wait_addr", sa, 32'h10);
    if (stall_o) stalls++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_hold_valid", bus_valid, 1);
      chk("wait_hold_addr", bus_addr, sa);
      chk("wait_hold_be", bus_be, sb);
      chk("wait_hold_wdata", bus_wdata, sw);
      chk("wait_early_done", done_o, 0);
      if (stall_o) stalls++;
      bus_ready = (k == 2);
    end
    @(negedge clk);
    got_done = done_o;
    chk("wait_done", got_done, 1);
    chk("wait_done_stall", stall_o, 0);
    chk("wait_stalls", stalls, 5);
    req_valid = 0;
    bus_ready = 0;
    @(negedge clk);
    chk("wait_done_single", done_o, 0);

    // Reset during BEAT1 of a split load abandons it.
    @(negedge clk);
    set_req(1, 1, 0, 2'd2, 0, 32'h102, 0);
    @(negedge clk);
    bus_ready = 1;
    bus_rdata = 32'h11223344;
    @(negedge clk);
    chk("rstb1_valid", bus_valid, 1);
    chk("rstb1_addr", bus_addr, 32'h104);
    reset = 1;
    bus_ready = 0;
    @(negedge clk);
    reset = 0;
    req_valid = 0;
    chk("rstb1_bus_valid", bus_valid, 0);
    chk("rstb1_rdata", rdata_o, 0);
    chk("rstb1_done", done_o, 0);
    #1;
    chk("rstb1_stall", stall_o, 0);
    @(negedge clk);
    chk("rstb1_done_after", done_o, 0);
    chk("rstb1_bus_after", bus_valid, 0);

    run_random(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data-RAM bus. It aligns stores, extracts and sign/zero-extends loads, and splits misaligned accesses into two word beats. It holds the pipeline through `stall_o`, which gates the enable of the EX/MEM and MEM/WB registers, until the access completes.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, fixed 32: bus word width. Any other value is illegal.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  EX/MEM slot holds a valid instruction.
- `req_load`  in  1  instruction is a load.
- `req_store`  in  1  instruction is a store.
- `req_size`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `req_unsigned`  in  1  zero-extend the load result (LBU/LHU).
- `req_addr`  in  ADDR_W  byte address (ALU result).
- `req_wdata`  in  32  store data, right-justified.
- `stall_o`  out  1  freeze upstream registers; combinational.
- `done_o`  out  1  one-cycle pulse when an access retires.
- `rdata_o`  out  32  extended load result; held until the next load retires.
- `bus_valid`  out  1  bus beat request.
- `bus_we`  out  1  beat is a write.
- `bus_addr`  out  ADDR_W  word-aligned beat address.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-aligned write data.
- `bus_ready`  in  1  beat accepted and completed this cycle.
- `bus_rdata`  in  32  read word; valid when `bus_valid & bus_ready & !bus_we`.

## Operation
- A memory op is `mem_op = req_valid & (req_load | req_store)`. If both load and store are set, the access is a store.
- On `mem_op` in IDLE, latch address, size, unsigned flag, data and direction.
  - `off = addr[1:0]`.
  - `nbytes` = 1, 2 or 4.
  - `split = (off + nbytes) > 4`.
- Store beat lanes, computed on a 64-bit intermediate:
  - `mask64 = ((1<<nbytes)-1) << off`.
  - `data64 = wdata << (8*off)`.
  - Beat0 uses the low 32 bits of each. Beat1 uses the high 32 bits.
- Beat addresses:
  - beat0 = `{addr[ADDR_W-1:2], 2'b00}`.
  - beat1 = beat0 + 4, modulo 2^ADDR_W. 0xFFFFFFFC wraps to 0x00000000.
- Loads:
  - Beat0 `bus_rdata` is stored in `lo`, beat1 in `hi`.
  - The result is `({hi,lo} >> 8*off)` truncated to `nbytes`, then sign- or zero-extended.
  - Loads drive `bus_be` to the same masks as stores. `bus_wdata` is don't-care, driven 0.
- FSM states:
  - **IDLE**: `stall_o = mem_op`. On `mem_op` → BEAT0.
  - **BEAT0**: `bus_valid = 1`. On `bus_ready`: → BEAT1 if `split`, else → DONE.
  - **BEAT1**: `bus_valid = 1`. On `bus_ready` → DONE.
  - **DONE**: `stall_o = 0`, `done_o = 1`. `rdata_o` is updated at entry to DONE for loads. → IDLE unconditionally.
- `stall_o = (IDLE & mem_op) | BEAT0 | BEAT1`.
- Bus outputs are held stable while `bus_valid & !bus_ready`.
- Non-memory instructions pass through IDLE with no stall and no bus activity.

## Timing
- Reset values: state IDLE, `stall_o` = 0 (unless `mem_op`), `done_o` = 0, `rdata_o` = 0, `bus_valid` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_be` = 0, `bus_wdata` = 0.
- Reset during BEAT0 or BEAT1:
  - `bus_valid` drops the next cycle.
  - The access is abandoned; no `done_o`, `rdata_o` = 0.
- Aligned access with `bus_ready` tied high: 3 cycles (IDLE, BEAT0, DONE), of which 2 are stalled. Split access: 4 cycles.
- Each cycle of `bus_ready` low in BEAT0 or BEAT1 adds one cycle.
- `rdata_o` is valid in the DONE cycle. The upstream register captures the next instruction at the end of DONE.
- A back-to-back memory op is first seen in the cycle after DONE. There is no bubble beyond that.

## Structure
- `lsu_pkg`:
  - `lsu_state_t` enum: IDLE, BEAT0, BEAT1, DONE.
  - Size encodings: `SZ_B`, `SZ_H`, `SZ_W`.
  - `nbytes` function.
- Sub-module `lsu_align`: combinational. Produces the 64-bit store lane mask and data, and performs load extract and extension. It is reused by the future cache path.
- The FSM and latches live in `mem_stage_lsu`.

## Test plan
- Word store 0xDEADBEEF @0x100, `bus_ready` = 1 → one beat: addr 0x100, be 1111, wdata 0xDEADBEEF. `stall_o` high 2 cycles, then `done_o`.
- LB @0x203, bus word 0x80123456 → be 1000, `rdata_o` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- Misaligned LW @0x102, beats 0x11223344 then 0x55667788 → addr 0x100 be 1100, then addr 0x104 be 0011. `rdata_o` = 0x77881122.
- SH 0xABCD @0xFFFFFFFF → beat0 0xFFFFFFFC be 1000 wdata 0xCD000000. Beat1 0x00000000 be 0001 wdata 0x000000AB.
- `bus_ready` low 3 cycles in BEAT0 → bus outputs stable, `stall_o` high 5 cycles, single `done_o`.
- Reset asserted in BEAT1 of a split load → next cycle IDLE, `bus_valid` = 0, `rdata_o` = 0, no `done_o`.
